// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, stop-bit check and a one-cycle ready/error strobe.
// Optional 8E1 framing with a parity-error strobe when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_byte_rdy,
    output logic       o_rx_busy,
    output logic       o_frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       o_parity_err
`endif
);

    localparam logic [15:0] HALF_CNT = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_CLEANUP,
        S_BREAK
    } state_t;

    state_t      state, state_d;
    logic        rx_meta, rx_s;
    logic [15:0] count, count_d;
    logic [2:0]  bit_idx, bit_idx_d;
    logic [7:0]  shift, shift_d;
    logic [7:0]  byte_d;
    logic        rdy_d, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic        parity_bit, parity_bit_d;
    logic        perr_d;
`endif

    // NOTE: i_rx is asynchronous; only the second stage may feed decisions.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d   = state;
        count_d   = count + 16'd1;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        byte_d    = o_rx_byte;
        rdy_d     = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_d = parity_bit;
        perr_d       = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                count_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (count == HALF_CNT) begin
                    count_d   = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (count == LAST_CNT) begin
                    count_d          = '0;
                    shift_d[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) begin
                        bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (count == LAST_CNT) begin
                    count_d      = '0;
                    parity_bit_d = rx_s;
                    state_d      = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (count == LAST_CNT) begin
                    count_d = '0;
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        // Even parity: data bits plus parity bit must XOR to zero.
                        if (^{shift, parity_bit}) begin
                            perr_d = 1'b1;
                        end else begin
                            byte_d = shift;
                            rdy_d  = 1'b1;
                        end
`else
                        byte_d = shift;
                        rdy_d  = 1'b1;
`endif
                        state_d = S_CLEANUP;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_CLEANUP: begin
                count_d = '0;
                state_d = S_IDLE;
            end
            S_BREAK: begin
                // A line held low must rise before the next start bit can be seen.
                count_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                count_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= S_IDLE;
            count         <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            o_rx_byte     <= '0;
            o_rx_byte_rdy <= 1'b0;
            o_frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit    <= 1'b0;
            o_parity_err  <= 1'b0;
`endif
        end else begin
            state         <= state_d;
            count         <= count_d;
            bit_idx       <= bit_idx_d;
            shift         <= shift_d;
            o_rx_byte     <= byte_d;
            o_rx_byte_rdy <= rdy_d;
            o_frame_err   <= ferr_d;
`ifdef UART_RX_PARITY_EN
            parity_bit    <= parity_bit_d;
            o_parity_err  <= perr_d;
`endif
        end
    end

    assign o_rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serial driver pushes expected events, a monitor pops them on each DUT strobe.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int HALF    = (CPB - 1) / 2;
    localparam int LATENCY = 2 + HALF + (FRAME_BITS - 1) * CPB + 1;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_rx;
    logic [7:0] o_rx_byte;
    logic       o_rx_byte_rdy;
    logic       o_rx_busy;
    logic       o_frame_err;
    logic       perr;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_rx          (i_rx),
        .o_rx_byte     (o_rx_byte),
        .o_rx_byte_rdy (o_rx_byte_rdy),
        .o_rx_busy     (o_rx_busy),
        .o_frame_err   (o_frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .o_parity_err  (perr)
`endif
    );
`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    always #5 i_clk = ~i_clk;

    typedef enum int {EV_RDY = 1, EV_FERR = 2, EV_PERR = 4} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    int         rdy_times[$];
    int         compared   = 0;
    int         mismatched = 0;
    int         cycle      = 0;
    logic [7:0] last_good  = 8'h00;

    always @(posedge i_clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        compared++;
        if (act < lo || act > hi) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge i_clk) begin
        if (o_rx_byte_rdy || o_frame_err || perr) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_strobe: rdy=%0b ferr=%0b perr=%0b byte=0x%0h, expected none",
                         o_rx_byte_rdy, o_frame_err, perr, o_rx_byte);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("strobe_kind", {29'd0, perr, o_frame_err, o_rx_byte_rdy}, 32'(e.kind));
                check("strobe_byte", {24'd0, o_rx_byte}, {24'd0, e.data});
            end
            if (o_rx_byte_rdy) rdy_times.push_back(cycle);
        end
    end

    task automatic idle(input int n);
        i_rx = 1'b1;
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Drives one frame; rst_bit >= 0 pulses reset mid-way through that frame bit and abandons the frame.
    task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit flip_par,
                              input int rst_bit, input bit chk_busy);
        logic [10:0] fr;
        ev_t         e;
        fr = '1;
        fr[0] = 1'b0;
        fr[8:1] = b;
`ifdef UART_RX_PARITY_EN
        fr[9]  = (^b) ^ flip_par;
        fr[10] = stop_bit;
`else
        fr[9] = stop_bit;
`endif
        if (rst_bit < 0) begin
            if (!stop_bit) begin
                e.kind = EV_FERR; e.data = last_good;
            end else if (flip_par) begin
                e.kind = EV_PERR; e.data = last_good;
            end else begin
                e.kind = EV_RDY; e.data = b; last_good = b;
            end
            exp_q.push_back(e);
        end
        for (int k = 0; k < FRAME_BITS; k++) begin
            i_rx = fr[k];
            for (int j = 0; j < CPB; j++) begin
                if (j == CPB / 2 && k == rst_bit) begin
                    i_rst = 1'b1;
                    i_rx  = 1'b1;
                    @(posedge i_clk);
                    #1;
                    i_rst = 1'b0;
                    last_good = 8'h00;
                    check("rst_byte", {24'd0, o_rx_byte}, 32'h0);
                    check("rst_rdy", {31'd0, o_rx_byte_rdy}, 32'h0);
                    check("rst_busy", {31'd0, o_rx_busy}, 32'h0);
                    check("rst_ferr", {31'd0, o_frame_err}, 32'h0);
                    return;
                end
                if (chk_busy && k >= 1 && j == CPB / 2)
                    check($sformatf("busy_bit%0d", k), {31'd0, o_rx_busy}, 32'h1);
                @(posedge i_clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(posedge i_clk);
            #1;
        end
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, base, n;
        int vals[256];

        i_rst = 1'b1;
        i_rx  = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_byte", {24'd0, o_rx_byte}, 32'h0);
        check("reset_rdy", {31'd0, o_rx_byte_rdy}, 32'h0);
        check("reset_busy", {31'd0, o_rx_busy}, 32'h0);
        check("reset_ferr", {31'd0, o_frame_err}, 32'h0);
        i_rst = 1'b0;
        idle(20);

        // Single good frame with latency and busy checks.
        t0 = cycle;
        send_frame(8'hA5, 1'b1, 1'b0, -1, 1'b1);
        wait_drain(4 * CPB);
        check("first_rdy_count", rdy_times.size(), 1);
        if (rdy_times.size() > 0)
            check_range("rdy_latency", rdy_times[0] - t0, LATENCY - 1, LATENCY + 1);
        idle(2 * CPB);

        // Short glitch on the line must be rejected.
        i_rx = 1'b0;
        repeat (5) begin
            @(posedge i_clk);
            #1;
        end
        i_rx = 1'b1;
        n = 0;
        repeat (30) begin
            @(posedge i_clk);
            #1;
            if (o_rx_busy) n++;
        end
        check_range("glitch_busy_cycles", n, 1, 11);

        // Framing error followed by a held-low break, then recovery.
        send_frame(8'h3C, 1'b0, 1'b0, -1, 1'b0);
        i_rx = 1'b0;
        repeat (24) begin
            @(posedge i_clk);
            #1;
        end
        check("break_busy", {31'd0, o_rx_busy}, 32'h1);
        idle(2 * CPB);
        check("break_released", {31'd0, o_rx_busy}, 32'h0);
        send_frame(8'h81, 1'b1, 1'b0, -1, 1'b0);
        idle(2 * CPB);

        // Back-to-back frames, no idle gap.
        base = rdy_times.size();
        send_frame(8'h00, 1'b1, 1'b0, -1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, -1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0, -1, 1'b0);
        wait_drain(4 * CPB);
        check("b2b_rdy_count", rdy_times.size() - base, 3);
        if (rdy_times.size() >= base + 3) begin
            check_range("b2b_spacing_1", rdy_times[base+1] - rdy_times[base],
                        FRAME_BITS * CPB - 1, FRAME_BITS * CPB + 1);
            check_range("b2b_spacing_2", rdy_times[base+2] - rdy_times[base+1],
                        FRAME_BITS * CPB - 1, FRAME_BITS * CPB + 1);
        end
        idle(CPB);

        // Reset in the middle of data bit 4, then the same byte again.
        send_frame(8'h7E, 1'b1, 1'b0, 5, 1'b0);
        idle(2 * CPB);
        send_frame(8'h7E, 1'b1, 1'b0, -1, 1'b0);
        idle(CPB);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b1, -1, 1'b0);
        idle(CPB);
`endif

        // All byte values in random order, with random gaps and occasional bad frames.
        for (int i = 0; i < 256; i++) vals[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j, t;
            j = $urandom_range(i);
            t = vals[i]; vals[i] = vals[j]; vals[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            bit bad_stop, bad_par;
            bad_stop = ($urandom_range(15) == 0);
`ifdef UART_RX_PARITY_EN
            bad_par = !bad_stop && ($urandom_range(15) == 0);
`else
            bad_par = 1'b0;
`endif
            send_frame(vals[i][7:0], !bad_stop, bad_par, -1, 1'b0);
            if (bad_stop) begin
                i_rx = 1'b0;
                repeat ($urandom_range(20)) begin
                    @(posedge i_clk);
                    #1;
                end
                idle(CPB + $urandom_range(CPB));
            end else begin
                idle($urandom_range(3) == 0 ? 0 : $urandom_range(2 * CPB));
            end
        end
        wait_drain(4 * FRAME_BITS * CPB);
        idle(4 * CPB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
